// File: rtl/alu_defs.sv
// Shared definitions for the ALU scheduler: opcodes, FSM states and the
// round-robin pick used when both requesters compete.
package alu_defs;

  // Datapath width the scheduler and ALU are built for.
  localparam int unsigned DataWidth = 16;

  // ALU opcodes as presented on rN_op.
  typedef enum logic [1:0] {
    OpAdd  = 2'b00,
    OpSub  = 2'b01,
    OpNand = 2'b10,
    OpNop  = 2'b11
  } op_e;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

  // Requester index to grant. A tie goes to the one not granted last;
  // a lone request wins regardless of history.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
      return ~last;
    end
    return ~v0;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Handshake bundle for the two requesters and the result consumer.
// master = requester/consumer side, slave = scheduler side.
interface alu_sched_if #(
  parameter int unsigned WIDTH = 16
);

  logic             r0_valid;
  logic             r0_ready;
  logic [WIDTH-1:0] r0_a;
  logic [WIDTH-1:0] r0_b;
  logic [1:0]       r0_op;

  logic             r1_valid;
  logic             r1_ready;
  logic [WIDTH-1:0] r1_a;
  logic [WIDTH-1:0] r1_b;
  logic [1:0]       r1_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_id;
  logic             out_nop;

  modport master (
    output r0_valid, r0_a, r0_b, r0_op,
    output r1_valid, r1_a, r1_b, r1_op,
    output out_ready,
    input  r0_ready, r1_ready,
    input  out_valid, out_result, out_id, out_nop
  );

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_op,
    input  r1_valid, r1_a, r1_b, r1_op,
    input  out_ready,
    output r0_ready, r1_ready,
    output out_valid, out_result, out_id, out_nop
  );

endinterface

// File: rtl/alu.sv
// Combinational ALU: ADD/SUB modulo 2^WIDTH, bitwise NAND, and a NOP that
// yields a clean zero plus a flag.
module alu
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             nop
);

  // Single arithmetic path; carry/borrow fall off the top naturally.
  always_comb begin
    result = '0;
    nop    = 1'b0;
    unique case (op)
      OpAdd:  result = a + b;
      OpSub:  result = a - b;
      OpNand: result = ~(a & b);
      OpNop:  nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Two-requester ALU scheduler: round-robin grant in IDLE, one cycle of
// execution, then hold the registered result until the consumer takes it.
module alu_sched
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic        clk,
  input logic        rst,
  alu_sched_if.slave bus
);

  state_e           state_q, state_d;
  logic             last_q, last_d;   // requester granted most recently
  logic             grant_any;
  logic             grant_id;

  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic             id_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             out_id_q;
  logic             nop_q;

  logic [WIDTH-1:0] alu_result;
  logic             alu_nop;

  // Next-state, arbitration and the combinational ready strobes.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_any    = 1'b0;
    grant_id     = 1'b0;
    bus.r0_ready = 1'b0;
    bus.r1_ready = 1'b0;
    case (state_q)
      StIdle: begin
        // Ready is masked during reset so nobody believes it was accepted.
        if (!rst && (bus.r0_valid || bus.r1_valid)) begin
          grant_any    = 1'b1;
          grant_id     = rr_pick(bus.r0_valid, bus.r1_valid, last_q);
          bus.r0_ready = ~grant_id;
          bus.r1_ready = grant_id;
          last_d       = grant_id;
          state_d      = StExec;
        end
      end
      StExec: state_d = StDone;
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset makes requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Capture the granted requester's operation on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OpAdd;
      id_q <= 1'b0;
    end else if (grant_any) begin
      a_q  <= grant_id ? bus.r1_a : bus.r0_a;
      b_q  <= grant_id ? bus.r1_b : bus.r0_b;
      op_q <= op_e'(grant_id ? bus.r1_op : bus.r0_op);
      id_q <= grant_id;
    end
  end

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .nop    (alu_nop)
  );

  // Result registers: loaded at the end of EXEC, held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_id_q    <= 1'b0;
      nop_q       <= 1'b0;
    end else if (state_q == StExec) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_result;
      out_id_q    <= id_q;
      nop_q       <= alu_nop;
    end else if (state_q == StDone && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_id     = out_id_q;
  assign bus.out_nop    = nop_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a
// transaction-level model.
module tb_alu_sched;
  import alu_defs::*;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sched_if #(.WIDTH(W)) bus ();

  alu_sched #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the opcode definitions, in plain integers.
  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
    int r;
    case (op)
      2'd0:    r = (int'(a) + int'(b)) % 65536;
      2'd1:    r = (int'(a) - int'(b) + 65536) % 65536;
      2'd2:    r = 65535 - (int'(a) & int'(b));
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  // Transaction-level model: at most one operation in flight, counted by age.
  bit          m_seen = 1'b0;
  bit          m_txn  = 1'b0;
  int          m_age  = 0;
  bit          m_last = 1'b1;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_op;
  bit          m_id;
  logic [15:0] m_res = '0;
  bit          m_oid = 1'b0;
  bit          m_nop = 1'b0;

  function automatic bit who_wins(input bit v0, input bit v1);
    if (v0 && v1) return !m_last;
    return !v0;
  endfunction

  always @(posedge clk) begin
    bit g;
    if (rst) begin
      m_seen = 1'b1;
      m_txn  = 1'b0;
      m_age  = 0;
      m_last = 1'b1;
      m_res  = '0;
      m_oid  = 1'b0;
      m_nop  = 1'b0;
    end else if (m_seen) begin
      if (!m_txn) begin
        if (bus.r0_valid || bus.r1_valid) begin
          g      = who_wins(bus.r0_valid, bus.r1_valid);
          m_txn  = 1'b1;
          m_age  = 0;
          m_id   = g;
          m_last = g;
          m_a    = g ? bus.r1_a : bus.r0_a;
          m_b    = g ? bus.r1_b : bus.r0_b;
          m_op   = g ? bus.r1_op : bus.r0_op;
        end
      end else if (m_age == 0) begin
        m_age = 1;
        m_res = ref_alu(m_a, m_b, m_op);
        m_oid = m_id;
        m_nop = (m_op == 2'd3);
      end else if (bus.out_ready) begin
        m_txn = 1'b0;
      end
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    bit any_v, w;
    if (m_seen) begin
      any_v = bus.r0_valid || bus.r1_valid;
      w     = who_wins(bus.r0_valid, bus.r1_valid);
      chk("r0_ready", 32'(bus.r0_ready), 32'(!rst && !m_txn && any_v && !w));
      chk("r1_ready", 32'(bus.r1_ready), 32'(!rst && !m_txn && any_v && w));
      chk("out_valid", 32'(bus.out_valid), 32'(m_txn && m_age >= 1));
      chk("out_result", 32'(bus.out_result), 32'(m_res));
      chk("out_id", 32'(bus.out_id), 32'(m_oid));
      chk("out_nop", 32'(bus.out_nop), 32'(m_nop));
      chk("no_x", 32'($isunknown({bus.out_valid, bus.out_result, bus.out_id, bus.out_nop,
                                  bus.r0_ready, bus.r1_ready})), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit v, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op);
    if (id) begin
      bus.r1_valid = v; bus.r1_a = a; bus.r1_b = b; bus.r1_op = op;
    end else begin
      bus.r0_valid = v; bus.r0_a = a; bus.r0_b = b; bus.r0_op = op;
    end
  endtask

  task automatic drain();
    bus.r0_valid  = 1'b0;
    bus.r1_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) tick();
  endtask

  // One isolated operation with literal expectations on grant, latency and result.
  task automatic run_one(input string tag, input bit id, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] op,
                         input logic [15:0] want, input bit want_nop);
    int n = 0;
    set_req(id, 1'b1, a, b, op);
    bus.out_ready = 1'b1;
    @(negedge clk);
    while (!(id ? bus.r1_ready : bus.r0_ready) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_granted"}, 32'(n < 10), 32'd1);
    chk({tag, "_other_ready"}, 32'(id ? bus.r0_ready : bus.r1_ready), 32'd0);
    tick();
    set_req(id, 1'b0, a, b, op);
    @(negedge clk);
    chk({tag, "_exec_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_exec_ready"}, 32'(id ? bus.r1_ready : bus.r0_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_result"}, 32'(bus.out_result), 32'(want));
    chk({tag, "_id"}, 32'(bus.out_id), 32'(id));
    chk({tag, "_nop"}, 32'(bus.out_nop), 32'(want_nop));
    tick();
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  g_seq[4];
    int  g_cnt, cyc;
    bit  g0, g1;

    bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_op = 2'd0;
    bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_op = 2'd0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_ready", 32'({bus.r0_ready, bus.r1_ready}), 32'd0);
    chk("rst_out", 32'({bus.out_valid, bus.out_id, bus.out_nop}), 32'd0);
    chk("rst_result", 32'(bus.out_result), 32'd0);
    rst = 1'b0;
    tick();

    // Wrap-around add, borrow on subtract, NAND, NOP.
    run_one("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 2'd0, 16'h0000, 1'b0);
    run_one("sub_borrow", 1'b1, 16'h0003, 16'h0005, 2'd1, 16'hFFFE, 1'b0);
    run_one("nand", 1'b1, 16'hF0F0, 16'hFF00, 2'd2, 16'h0FFF, 1'b0);
    run_one("nop", 1'b0, 16'h1234, 16'h5678, 2'd3, 16'h0000, 1'b1);
    drain();

    // Both held valid from reset: grants alternate starting with r0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1'b0, 1'b1, 16'h0010, 16'h0001, 2'd0);
    set_req(1'b1, 1'b1, 16'h0020, 16'h0002, 2'd1);
    g_cnt = 0;
    cyc   = 0;
    while (g_cnt < 4 && cyc < 40) begin
      @(negedge clk);
      if (bus.r0_ready) begin
        g_seq[g_cnt] = 0; g_cnt++;
      end else if (bus.r1_ready) begin
        g_seq[g_cnt] = 1; g_cnt++;
      end
      cyc++;
    end
    chk("rr_count", 32'(g_cnt), 32'd4);
    for (int i = 0; i < g_cnt; i++) chk("rr_order", 32'(g_seq[i]), 32'(i % 2));
    tick();
    drain();

    // Consumer stalls five cycles in DONE with both requesters waiting.
    set_req(1'b0, 1'b1, 16'h0001, 16'h0002, 2'd0);
    cyc = 0;
    @(negedge clk);
    while (!bus.r0_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    tick();
    bus.out_ready = 1'b0;
    set_req(1'b1, 1'b1, 16'h00FF, 16'h0F0F, 2'd2);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_result", 32'(bus.out_result), 32'h0003);
      chk("stall_id", 32'(bus.out_id), 32'd0);
      chk("stall_ready", 32'({bus.r0_ready, bus.r1_ready}), 32'd0);
      if (i < 4) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("stall_release_r1", 32'(bus.r1_ready), 32'd1);
    tick();
    drain();

    // Reset while in EXEC abandons the operation.
    set_req(1'b1, 1'b1, 16'h0100, 16'h0001, 2'd0);
    cyc = 0;
    @(negedge clk);
    while (!bus.r1_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    tick();
    set_req(1'b1, 1'b0, 16'h0100, 16'h0001, 2'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_exec_ready", 32'({bus.r0_ready, bus.r1_ready}), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("rst_exec_still_idle", 32'(bus.out_valid), 32'd0);
    tick();
    run_one("after_rst", 1'b0, 16'h0010, 16'h0001, 2'd1, 16'h000F, 1'b0);
    drain();

    // Randomized traffic with stalls and occasional resets.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      g0 = bus.r0_ready;
      g1 = bus.r1_ready;
      tick();
      if (g0 || !bus.r0_valid)
        set_req(1'b0, 1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
                2'($urandom_range(0, 3)));
      if (g1 || !bus.r1_valid)
        set_req(1'b1, 1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
                2'($urandom_range(0, 3)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; only 16 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 r0_valid  input  1  requester 0 has an operation pending.
REQ-005 r0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 r0_a, r0_b  input  16 each  requester 0 operands.
REQ-007 r0_op  input  2  requester 0 opcode (00 ADD, 01 SUB, 10 NAND, 11 NOP).
REQ-008 r1_valid, r1_ready, r1_a, r1_b, r1_op  as REQ-004..007 for requester 1.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out_result  output  16  registered ALU result.
REQ-012 out_id  output  1  index of requester that owns out_result.
REQ-013 out_nop  output  1  result came from opcode 11.

Function
REQ-014 FSM states IDLE, EXEC, DONE; one-hot or binary encoding is implementer's choice.
REQ-015 IDLE: if any rN_valid, grant one requester, assert its rN_ready for exactly that cycle, latch a, b, op, id; go EXEC.
REQ-016 Arbitration round-robin: both valid -> grant requester not granted last; single valid -> grant it regardless of history.
REQ-017 rN_ready SHALL be combinational from state and valids, high only in IDLE, never both high.
REQ-018 EXEC: drive latched operands into ALU, register result into out_result; go DONE (one cycle).
REQ-019 DONE: out_valid=1; out_result, out_id, out_nop stable until out_valid&out_ready, then go IDLE.
REQ-020 Latency: acceptance at cycle N -> out_valid at N+2; minimum issue interval 3 cycles.
REQ-021 Arithmetic modulo 2^16; carry/borrow discarded (0xFFFF+1=0x0000, 3-5=0xFFFE).
REQ-022 Opcode 11: out_result SHALL be 16'h0000 (no Z/X forwarded), out_nop=1; else out_nop=0.
REQ-023 Requests not granted are not dropped; requester holds valid/operands until its ready.
REQ-024 New requests arriving in EXEC/DONE are ignored until IDLE.

Reset
REQ-025 rst high at an edge -> state IDLE, out_valid=0, out_result=0, out_id=0, out_nop=0, last-grant=1 (requester 0 wins first tie).
REQ-026 Reset mid-operation (EXEC or DONE) SHALL abandon the in-flight result; no out_valid after reset deasserts until a new grant.
REQ-027 rN_ready SHALL be 0 while rst is high.

Structure
REQ-028 Opcode constants (ADD, SUB, NAND, NOP) and state encodings in a shared definitions file/package alu_defs, used by alu_sched and the ALU.
REQ-029 The existing combinational ALU SHALL be instantiated once as sub-module alu; no second arithmetic path.
REQ-030 All outputs except rN_ready SHALL be registered.

Verification
REQ-031 r0: ADD 0xFFFF,0x0001 -> r0_ready 1 cycle, 2 cycles later out_valid, out_result 0x0000, out_id 0.
REQ-032 r1: SUB 0x0003,0x0005 then NAND 0xF0F0,0xFF00 -> 0xFFFE then 0x0FFF, out_id 1.
REQ-033 r0 and r1 valid together from reset, held -> grants r0, r1, r0, r1 alternating.
REQ-034 op 11 with a=0x1234 -> out_result 0x0000, out_nop 1, no X/Z on outputs.
REQ-035 out_ready low 5 cycles in DONE -> outputs stable, no rN_ready until handshake.
REQ-036 rst asserted in EXEC -> next cycle IDLE, out_valid 0; following request completes normally.
